// File: rtl/vga_frame_driver_if.sv
// ---------------------------------------------------------------------------
// tIVgaDriver
// DAC-side bundle between the VGA pixel-timing engine and the ADV7123 video
// DAC.  The driver modport sources every signal; the dac modport is the
// mirror view for the board-level DAC wrapper.
//
// Signals:
//   ul1VgaClock    DAC sample clock (inverted pixel clock)
//   ul8VgaRed      red component
//   ul8VgaGreen    green component
//   ul8VgaBlue     blue component
//   ul1VgaBlank_n  low outside the visible area
//   ul1VgaSync_n   composite sync for sync-on-green (unused, held low)
//   ul1VgaHSync    horizontal sync to the monitor connector
//   ul1VgaVSync    vertical sync to the monitor connector
// ---------------------------------------------------------------------------
interface tIVgaDriver;
   logic       ul1VgaClock;
   logic [7:0] ul8VgaRed;
   logic [7:0] ul8VgaGreen;
   logic [7:0] ul8VgaBlue;
   logic       ul1VgaBlank_n;
   logic       ul1VgaSync_n;
   logic       ul1VgaHSync;
   logic       ul1VgaVSync;

   modport driver (
      output ul1VgaClock,
      output ul8VgaRed,
      output ul8VgaGreen,
      output ul8VgaBlue,
      output ul1VgaBlank_n,
      output ul1VgaSync_n,
      output ul1VgaHSync,
      output ul1VgaVSync
   );

   modport dac (
      input ul1VgaClock,
      input ul8VgaRed,
      input ul8VgaGreen,
      input ul8VgaBlue,
      input ul1VgaBlank_n,
      input ul1VgaSync_n,
      input ul1VgaHSync,
      input ul1VgaVSync
   );
endinterface

// File: rtl/vga_frame_driver.sv
// ---------------------------------------------------------------------------
// vga_frame_driver
// Pixel-timing engine feeding the ADV7123 DAC.  Generates raster timing
// (640x480@60 by default) from the pixel clock, pulls RGB pixels from the
// frame source over a valid/ready stream and keeps that stream aligned to
// the raster with a start-of-frame marker.  Whenever the stream runs dry or
// its SOF lands in the wrong place the output goes black and the driver
// hunts for the next SOF, locking again at the following frame boundary.
//
// Optional feature macro: VGA_DRIVER_TEST_PATTERN_EN
//   When defined, adds input ul1TestPatternSel.  While it is high the
//   output shows eight vertical colour bars and the stream is ignored.
//
// Ports:
//   ul1Clock          pixel clock, sole clock
//   ul1Reset_n        asynchronous active-low reset
//   ul24PixelData     source pixel {R[23:16], G[15:8], B[7:0]}
//   ul1PixelSof       source pixel is pixel (0,0) of a frame
//   ul1PixelValid     source has a pixel
//   ul1PixelReady     driver takes the pixel this cycle
//   ul1FrameStart     high while the counters sit at (0,0)
//   ul1Locked         stream is aligned to the raster
//   ul1Underflow      one-cycle pulse per underflow / misalignment event
//   ul1TestPatternSel colour-bar select (only with the macro above)
//   ivVga             DAC-side outputs (tIVgaDriver.driver)
// ---------------------------------------------------------------------------
module vga_frame_driver #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        ul1Clock,
   input  logic        ul1Reset_n,
   input  logic [23:0] ul24PixelData,
   input  logic        ul1PixelSof,
   input  logic        ul1PixelValid,
`ifdef VGA_DRIVER_TEST_PATTERN_EN
   input  logic        ul1TestPatternSel,
`endif
   output logic        ul1PixelReady,
   output logic        ul1FrameStart,
   output logic        ul1Locked,
   output logic        ul1Underflow,
   tIVgaDriver.driver  ivVga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ONE      = HW'(1);
   localparam logic [VW-1:0] V_ONE      = VW'(1);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_DRIVER_TEST_PATTERN_EN
   localparam logic [HW-1:0] BAR_WIDTH  = HW'(H_ACTIVE / 8);
`endif

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tDriverState;

   logic [HW-1:0] hCnt;
   logic [VW-1:0] vCnt;
   tDriverState   stateQ;
   tDriverState   stateNext;

   logic          active;
   logic          atOrigin;
   logic          atLast;
   logic          hSyncOn;
   logic          vSyncOn;
   logic          pixelReady;
   logic          underflowEvent;
   logic          showPixel;
   logic [23:0]   rgbNext;

   logic [23:0]   rgbQ;
   logic          blankQ;
   logic          hSyncQ;
   logic          vSyncQ;

`ifdef VGA_DRIVER_TEST_PATTERN_EN
   logic [2:0]    barIdx;
   logic [23:0]   barColour;
`endif

   // Raster position.  (0,0) is the first visible pixel, so the blanking
   // intervals sit at the high end of each counter and a frame ends at
   // (H_TOTAL-1, V_TOTAL-1).
   always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
      if (!ul1Reset_n) begin
         hCnt <= '0;
         vCnt <= '0;
      end else if (hCnt == H_LAST) begin
         hCnt <= '0;
         vCnt <= (vCnt == V_LAST) ? '0 : vCnt + V_ONE;
      end else begin
         hCnt <= hCnt + H_ONE;
      end
   end

   // Position decodes shared by the stream FSM and the output register.
   always_comb begin
      active   = (hCnt < H_VIS) && (vCnt < V_VIS);
      atOrigin = (hCnt == '0) && (vCnt == '0);
      atLast   = (hCnt == H_LAST) && (vCnt == V_LAST);
      hSyncOn  = (hCnt >= HS_FIRST) && (hCnt <= HS_LAST);
      vSyncOn  = (vCnt >= VS_FIRST) && (vCnt <= VS_LAST);
   end

`ifdef VGA_DRIVER_TEST_PATTERN_EN
   // Bar index comes straight from the column.  Each colour component is
   // on for a fixed half of the eight bars, which yields the order white,
   // yellow, cyan, green, magenta, red, blue, black.
   always_comb begin
      barIdx    = 3'(hCnt / BAR_WIDTH);
      barColour = {{8{~barIdx[1]}}, {8{~barIdx[2]}}, {8{~barIdx[0]}}};
   end
`endif

   // Stream state register.
   always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
      if (!ul1Reset_n) begin
         stateQ <= HUNT;
      end else begin
         stateQ <= stateNext;
      end
   end

   // Next-state, handshake and pixel selection.  In HUNT everything that
   // is not an SOF pixel is drained so stale data from a broken frame never
   // reaches the screen, while an SOF pixel is held until the raster wraps
   // to (0,0).  In LOCKED one pixel is taken per visible position; a
   // missing pixel, a missing SOF at the origin or an SOF anywhere else
   // blanks that position and drops back to HUNT.  A misplaced SOF is not
   // consumed, so it becomes the first pixel of the next locked frame.
   always_comb begin
      stateNext      = stateQ;
      pixelReady     = 1'b0;
      underflowEvent = 1'b0;
      showPixel      = 1'b0;

      case (stateQ)
         HUNT: begin
            pixelReady = !(ul1PixelValid && ul1PixelSof);
            if (atLast && ul1PixelValid && ul1PixelSof) begin
               stateNext = LOCKED;
            end
         end
         LOCKED: begin
            pixelReady = active;
            if (atOrigin && !(ul1PixelValid && ul1PixelSof)) begin
               pixelReady     = 1'b0;
               underflowEvent = 1'b1;
               stateNext      = HUNT;
            end else if (active && !atOrigin && ul1PixelValid && ul1PixelSof) begin
               pixelReady     = 1'b0;
               underflowEvent = 1'b1;
               stateNext      = HUNT;
            end else if (active && !ul1PixelValid) begin
               underflowEvent = 1'b1;
               stateNext      = HUNT;
            end else if (active) begin
               showPixel = 1'b1;
            end
         end
         default: begin
            stateNext = HUNT;
         end
      endcase

      rgbNext = showPixel ? ul24PixelData : 24'h000000;

`ifdef VGA_DRIVER_TEST_PATTERN_EN
      if (ul1TestPatternSel) begin
         stateNext      = HUNT;
         pixelReady     = 1'b0;
         underflowEvent = 1'b0;
         rgbNext        = active ? barColour : 24'h000000;
      end
`endif
   end

   // Output register.  Colour, blanking and both syncs for a raster
   // position are all captured on the same edge, so they reach the DAC
   // together one clock after that position.
   always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
      if (!ul1Reset_n) begin
         rgbQ   <= 24'h000000;
         blankQ <= 1'b0;
         hSyncQ <= ~SYNC_POL;
         vSyncQ <= ~SYNC_POL;
      end else begin
         rgbQ   <= rgbNext;
         blankQ <= active;
         hSyncQ <= hSyncOn ? SYNC_POL : ~SYNC_POL;
         vSyncQ <= vSyncOn ? SYNC_POL : ~SYNC_POL;
      end
   end

   // Frame-start is masked during reset because the counters already read
   // (0,0) there but no frame is starting yet.
   assign ul1FrameStart = atOrigin && ul1Reset_n;
   assign ul1PixelReady = pixelReady;
   assign ul1Underflow  = underflowEvent;
   assign ul1Locked     = (stateQ == LOCKED);

   // The DAC latches on the falling pixel-clock edge, mid-way through the
   // data eye of the rising-edge output register.
   assign ivVga.ul1VgaClock   = ~ul1Clock;
   assign ivVga.ul8VgaRed     = rgbQ[23:16];
   assign ivVga.ul8VgaGreen   = rgbQ[15:8];
   assign ivVga.ul8VgaBlue    = rgbQ[7:0];
   assign ivVga.ul1VgaBlank_n = blankQ;
   assign ivVga.ul1VgaSync_n  = 1'b0;
   assign ivVga.ul1VgaHSync   = hSyncQ;
   assign ivVga.ul1VgaVSync   = vSyncQ;

endmodule

// File: tb/tb_vga_frame_driver.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_driver
// Directed bench for vga_frame_driver on a shrunken raster (24x11 total,
// 16x6 visible) so whole frames pass in a few hundred cycles.  A small
// source model streams numbered pixels and can drop valid or rewind to
// SOF at a chosen raster position.  Inputs are driven and outputs sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vga_frame_driver;

   localparam int HA = 16;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 3;
   localparam int VA = 6;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int NPIX  = HA * VA;
   localparam int FRAME = HT * VT;

   typedef struct {
      string       name;
      int          h;
      int          v;
      logic [23:0] rgb;
      logic        blank;
      logic        hs;
      logic        vs;
   } tVector;

   logic        clock = 1'b0;
   logic        resetN;
   logic [23:0] pixelData = 24'h0;
   logic        pixelSof = 1'b0;
   logic        pixelValid = 1'b0;
   logic        testSel = 1'b0;
   logic        pixelReady;
   logic        frameStart;
   logic        locked;
   logic        underflow;
   logic [23:0] rgb;

   tIVgaDriver vga();

   vga_frame_driver #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0)
   ) dut (
      .ul1Clock(clock),
      .ul1Reset_n(resetN),
      .ul24PixelData(pixelData),
      .ul1PixelSof(pixelSof),
      .ul1PixelValid(pixelValid),
`ifdef VGA_DRIVER_TEST_PATTERN_EN
      .ul1TestPatternSel(testSel),
`endif
      .ul1PixelReady(pixelReady),
      .ul1FrameStart(frameStart),
      .ul1Locked(locked),
      .ul1Underflow(underflow),
      .ivVga(vga)
   );

   assign rgb = {vga.ul8VgaRed, vga.ul8VgaGreen, vga.ul8VgaBlue};

   always #20 clock = ~clock;

   // Raster position the next rising edge will process.
   int tbH;
   int tbV;
   always @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         tbH <= 0;
         tbV <= 0;
      end else if (tbH == HT - 1) begin
         tbH <= 0;
         tbV <= (tbV == VT - 1) ? 0 : tbV + 1;
      end else begin
         tbH <= tbH + 1;
      end
   end

   int passCount = 0;
   int checkCount = 0;

   // Source model state.
   int srcIdx = 0;
   bit srcEn = 1'b0;
   bit fire = 1'b0;
   int dropH = -1;
   int dropV = -1;
   int rewH = -1;
   int rewV = -1;

   tVector vecs[$];
   int idleEnd;
   int hsLow;
   int vsLow;
   int fsCount;
   int fsTick[$];

   function automatic logic [23:0] pixData(int idx);
      logic [7:0] b;
      b = 8'(idx);
      if (idx == 2 * HA + 5) return 24'h123456;
      return {8'h40 ^ b, b + 8'h11, ~b};
   endfunction

   task automatic checkOutput(string name, logic [23:0] actual, logic [23:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic checkBit(string name, logic actual, logic expected);
      checkOutput(name, 24'(actual), 24'(expected));
   endtask

   // One pixel clock: settle the previous handshake, then present the
   // source pixel for the position the next rising edge processes.
   task automatic applyStimulus();
      @(negedge clock);
      if (fire) srcIdx = (srcIdx + 1) % NPIX;
      if (tbH == rewH && tbV == rewV) srcIdx = 0;
      pixelValid = srcEn && !(tbH == dropH && tbV == dropV);
      pixelData  = pixData(srcIdx);
      pixelSof   = (srcIdx == 0);
      #1;
      fire = pixelValid && pixelReady;
   endtask

   task automatic stepTo(int h, int v);
      int budget;
      budget = 2 * FRAME;
      do begin
         applyStimulus();
         budget--;
      end while (!(tbH == h && tbV == v) && budget > 0);
      if (!(tbH == h && tbV == v)) begin
         checkCount++;
         $display("[TB] FAIL stepTo: position %0d,%0d never reached", h, v);
      end
   endtask

   task automatic checkVector(tVector t);
      stepTo(t.h, t.v);
      applyStimulus();
      checkOutput({t.name, " rgb"}, rgb, t.rgb);
      checkBit({t.name, " blank_n"}, vga.ul1VgaBlank_n, t.blank);
      checkBit({t.name, " hsync"}, vga.ul1VgaHSync, t.hs);
      checkBit({t.name, " vsync"}, vga.ul1VgaVSync, t.vs);
   endtask

   task automatic addVec(string name, int h, int v, logic [23:0] c, logic b, logic hs, logic vs);
      tVector t;
      t.name = name; t.h = h; t.v = v; t.rgb = c; t.blank = b; t.hs = hs; t.vs = vs;
      vecs.push_back(t);
   endtask

   initial begin
      // Idle raster after reset; hsync low for h 18..20, vsync low for v 7..8.
      addVec("idle first",        2,  0, 24'h0, 1'b1, 1'b1, 1'b1);
      addVec("idle last visible", 15, 0, 24'h0, 1'b1, 1'b1, 1'b1);
      addVec("idle front porch",  17, 0, 24'h0, 1'b0, 1'b1, 1'b1);
      addVec("idle hsync end",    20, 0, 24'h0, 1'b0, 1'b0, 1'b1);
      addVec("idle hsync start",  18, 1, 24'h0, 1'b0, 1'b0, 1'b1);
      addVec("idle back porch",   21, 1, 24'h0, 1'b0, 1'b1, 1'b1);
      addVec("idle last line",    0,  5, 24'h0, 1'b1, 1'b1, 1'b1);
      addVec("idle vblank",       0,  6, 24'h0, 1'b0, 1'b1, 1'b1);
      addVec("idle vsync first",  3,  7, 24'h0, 1'b0, 1'b1, 1'b0);
      addVec("idle vsync hsync",  19, 7, 24'h0, 1'b0, 1'b0, 1'b0);
      addVec("idle vsync last",   22, 8, 24'h0, 1'b0, 1'b1, 1'b0);
      addVec("idle after vsync",  0,  9, 24'h0, 1'b0, 1'b1, 1'b1);
      idleEnd = vecs.size();
      // First locked frame, source numbering pixels from 0 at the origin.
      addVec("lock pixel 5,2",    5,  2, 24'h123456,   1'b1, 1'b1, 1'b1);
      addVec("lock line end",     15, 2, pixData(47),  1'b1, 1'b1, 1'b1);
      addVec("lock porch",        17, 2, 24'h0,        1'b0, 1'b1, 1'b1);
      addVec("lock hsync",        19, 2, 24'h0,        1'b0, 1'b0, 1'b1);
      addVec("lock next line",    0,  3, pixData(48),  1'b1, 1'b1, 1'b1);
      addVec("lock final pixel",  15, 5, pixData(95),  1'b1, 1'b1, 1'b1);
      addVec("lock vblank",       2,  6, 24'h0,        1'b0, 1'b1, 1'b1);

      // Reset values while reset is held.
      resetN = 1'b1;
      #5 resetN = 1'b0;
      repeat (10) @(negedge clock);
      #1;
      checkOutput("reset rgb", rgb, 24'h0);
      checkBit("reset blank_n", vga.ul1VgaBlank_n, 1'b0);
      checkBit("reset hsync", vga.ul1VgaHSync, 1'b1);
      checkBit("reset vsync", vga.ul1VgaVSync, 1'b1);
      checkBit("reset frameStart", frameStart, 1'b0);
      checkBit("reset underflow", underflow, 1'b0);
      checkBit("reset locked", locked, 1'b0);
      resetN = 1'b1;
      #1;
      checkBit("release frameStart", frameStart, 1'b1);

      for (int i = 0; i < idleEnd; i++) checkVector(vecs[i]);

      // Two idle frames of sync and frame-start statistics.
      stepTo(HT - 1, VT - 1);
      hsLow = 0; vsLow = 0; fsCount = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         applyStimulus();
         if (vga.ul1VgaHSync === 1'b0) hsLow++;
         if (vga.ul1VgaVSync === 1'b0) vsLow++;
         if (frameStart === 1'b1) begin
            fsCount++;
            fsTick.push_back(i);
         end
      end
      checkOutput("hsync low cycles", 24'(hsLow), 24'(2 * VT * HS));
      checkOutput("vsync low cycles", 24'(vsLow), 24'(2 * VS * HT));
      checkOutput("frameStart count", 24'(fsCount), 24'd2);
      if (fsTick.size() == 2) checkOutput("frameStart period", 24'(fsTick[1] - fsTick[0]), 24'(FRAME));

      // Source starts at SOF; it is held through the hunting frame.
      srcEn = 1'b1; srcIdx = 0; fire = 1'b0;
      applyStimulus();
      checkBit("hunt holds sof ready", pixelReady, 1'b0);
      stepTo(5, 3);
      checkBit("hunt mid-frame ready", pixelReady, 1'b0);
      checkBit("hunt mid-frame locked", locked, 1'b0);
      stepTo(HT - 1, VT - 1);
      checkBit("hunt end locked", locked, 1'b0);
      applyStimulus();
      checkBit("lock at origin", locked, 1'b1);
      checkBit("lock frameStart", frameStart, 1'b1);
      checkBit("lock origin ready", pixelReady, 1'b1);
      applyStimulus();
      checkOutput("lock origin pixel", rgb, pixData(0));
      for (int i = idleEnd; i < vecs.size(); i++) checkVector(vecs[i]);

      // Valid dropped for one visible cycle.
      dropH = 10; dropV = 3;
      stepTo(10, 3);
      checkBit("drop underflow pulse", underflow, 1'b1);
      applyStimulus();
      dropH = -1; dropV = -1;
      checkOutput("drop pixel black", rgb, 24'h0);
      checkBit("drop underflow single", underflow, 1'b0);
      checkBit("drop unlocked", locked, 1'b0);
      checkBit("drop drain ready", pixelReady, 1'b1);
      applyStimulus();
      checkOutput("drain black", rgb, 24'h0);
      stepTo(HT - 1, VT - 1);
      checkBit("drain sof held", pixelReady, 1'b0);
      applyStimulus();
      checkBit("relock after drain", locked, 1'b1);
      applyStimulus();
      checkOutput("relock origin pixel", rgb, pixData(0));
      stepTo(5, 1);
      applyStimulus();
      checkOutput("relock pixel 5,1", rgb, pixData(21));

      // Source rewinds to SOF in the middle of a locked frame.
      rewH = 8; rewV = 2;
      stepTo(8, 2);
      rewH = -1; rewV = -1;
      checkBit("misplaced sof ready", pixelReady, 1'b0);
      checkBit("misplaced sof underflow", underflow, 1'b1);
      applyStimulus();
      checkOutput("misplaced sof black", rgb, 24'h0);
      checkBit("misplaced sof unlocked", locked, 1'b0);
      stepTo(HT - 1, VT - 1);
      applyStimulus();
      checkBit("relock after sof", locked, 1'b1);
      applyStimulus();
      checkOutput("held sof at origin", rgb, pixData(0));

      // Reset asserted mid-frame.
      stepTo(12, 4);
      checkOutput("pre-reset pixel", rgb, pixData(4 * HA + 11));
      resetN = 1'b0;
      #1;
      checkOutput("mid reset rgb", rgb, 24'h0);
      checkBit("mid reset blank_n", vga.ul1VgaBlank_n, 1'b0);
      checkBit("mid reset hsync", vga.ul1VgaHSync, 1'b1);
      checkBit("mid reset vsync", vga.ul1VgaVSync, 1'b1);
      checkBit("mid reset locked", locked, 1'b0);
      checkBit("mid reset underflow", underflow, 1'b0);
      checkBit("mid reset frameStart", frameStart, 1'b0);
      repeat (3) @(negedge clock);
      srcEn = 1'b0; srcIdx = 0; fire = 1'b0;
      pixelValid = 1'b0;
      resetN = 1'b1;
      #1;
      checkBit("restart frameStart", frameStart, 1'b1);
      applyStimulus();
      checkBit("restart origin blank_n", vga.ul1VgaBlank_n, 1'b1);
      checkOutput("restart origin rgb", rgb, 24'h0);
      checkBit("restart frameStart off", frameStart, 1'b0);

`ifdef VGA_DRIVER_TEST_PATTERN_EN
      // Colour bars: bar width is 2 pixels here, so h=3 is the yellow bar.
      srcEn = 1'b1;
      testSel = 1'b1;
      stepTo(3, 1);
      checkBit("pattern ready", pixelReady, 1'b0);
      applyStimulus();
      checkOutput("pattern yellow bar", rgb, 24'hFFFF00);
      checkBit("pattern locked", locked, 1'b0);
      stepTo(14, 1);
      applyStimulus();
      checkOutput("pattern black bar", rgb, 24'h000000);
      stepTo(9, 1);
      applyStimulus();
      checkOutput("pattern magenta bar", rgb, 24'hFF00FF);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Overall time limit in case a wait never completes.
   initial begin
      #(100000 * 40);
      $display("[TB] FAIL watchdog: time limit reached, %0d/%0d passed", passCount, checkCount);
      $fatal(1, "[TB] time limit");
   end

endmodule
